// File: rtl/keypad_scanner_db_if.sv
// Keypad scanner bus: raw row sense into the scanner, column drive and the debounced key report out.
interface keypad_scanner_db_if #(
  parameter int N_ROWS  = 4,
  parameter int N_COLS  = 4,
  parameter int HEX_MAP = 1
);
  localparam int CW_RAW = $clog2(N_ROWS * N_COLS);
  localparam int CW     = (HEX_MAP != 0 && CW_RAW < 4) ? 4 : CW_RAW;

  logic [N_ROWS-1:0] row;
  logic [N_COLS-1:0] col;
  logic [CW-1:0]     key_code;
  logic              key_valid;
  logic              key_press;
  logic              key_release;
  logic              multi_key;

  modport master (input row, output col, key_code, key_valid, key_press, key_release, multi_key);
  modport slave  (output row, input col, key_code, key_valid, key_press, key_release, multi_key);
endinterface

// File: rtl/keypad_scanner_db.sv
// Matrix keypad scanner: one-cold column drive, per-frame key accumulation, multi-frame debounce
// and a committed key report with press/release strobes and multi-key detection.
module keypad_scanner_db #(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_TICKS     = 100000,
  parameter int SETTLE_TICKS   = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int HEX_MAP        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_scanner_db_if.master bus
);
  localparam int CW_RAW  = $clog2(N_ROWS * N_COLS);
  localparam int CW      = (HEX_MAP != 0 && CW_RAW < 4) ? 4 : CW_RAW;
  localparam bit USE_HEX = (HEX_MAP != 0) && (N_ROWS == 4) && (N_COLS == 4);
  localparam int TW      = $clog2(SCAN_TICKS);
  localparam int XW      = $clog2(N_COLS);
  localparam int DW      = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] TICK_SAMPLE = TW'(SETTLE_TICKS);
  localparam logic [XW-1:0] COL_LAST    = XW'(N_COLS - 1);
  localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_SCANS);

  // Row-major legend: row 0 reads 1,2,3,A across columns 0..3.
  localparam logic [3:0] LEGEND [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'h0, 4'hF, 4'hE, 4'hD};

  typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_t;

  function automatic logic [N_COLS-1:0] colDrive(input logic [XW-1:0] idx);
    return ~(N_COLS'(1) << (N_COLS - 1 - int'(idx)));
  endfunction

  function automatic logic [CW-1:0] codeOf(input int r, input logic [XW-1:0] c);
    logic [3:0] legendIdx;
    legendIdx = 4'((r * 4) + int'(c));
    if (USE_HEX) return CW'(LEGEND[legendIdx]);
    return CW'((r * N_COLS) + int'(c));
  endfunction

  logic [N_ROWS-1:0] r_rowMeta, r_rowSync;
  logic [TW-1:0]     r_tick;
  logic [XW-1:0]     r_colIdx;
  logic [N_COLS-1:0] r_col;
  logic [1:0]        r_accCount;
  logic [CW-1:0]     r_accCode;
  cand_t             r_prevKind, r_comKind;
  logic [CW-1:0]     r_prevCode;
  logic [DW-1:0]     r_dbCnt;
  logic [CW-1:0]     r_keyCode;
  logic              r_keyValid, r_keyPress, r_keyRelease, r_multiKey;

  logic              w_tickLast, w_frameEnd, w_sample, w_same, w_differs, w_commit;
  logic [XW-1:0]     w_nextCol;
  logic [1:0]        w_hits, w_accSum;
  logic [2:0]        w_accRaw;
  logic [CW-1:0]     w_firstCode;
  cand_t             w_candKind;
  logic [DW-1:0]     w_nextCnt;

  always_comb begin
    w_tickLast  = (r_tick == TICK_LAST);
    w_frameEnd  = w_tickLast && (r_colIdx == COL_LAST);
    w_sample    = (r_tick == TICK_SAMPLE);
    w_nextCol   = (r_colIdx == COL_LAST) ? '0 : r_colIdx + XW'(1);
    w_hits      = 2'd0;
    w_firstCode = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (!r_rowSync[N_ROWS-1-r]) begin
        if (w_hits == 2'd0) w_firstCode = codeOf(r, r_colIdx);
        if (w_hits != 2'd2) w_hits = w_hits + 2'd1;
      end
    end
    w_accRaw = {1'b0, r_accCount} + {1'b0, w_hits};
    w_accSum = (w_accRaw >= 3'd2) ? 2'd2 : w_accRaw[1:0];

    if (r_accCount == 2'd0)      w_candKind = CAND_NONE;
    else if (r_accCount == 2'd1) w_candKind = CAND_KEY;
    else                         w_candKind = CAND_MULTI;
    // A key code only matters for identity when the candidate is a single key.
    w_same    = (w_candKind == r_prevKind) && ((w_candKind != CAND_KEY) || (r_accCode == r_prevCode));
    w_nextCnt = !w_same ? DW'(1) : ((r_dbCnt == DB_MAX) ? r_dbCnt : r_dbCnt + DW'(1));
    w_differs = (w_candKind != r_comKind) || ((w_candKind == CAND_KEY) && (r_accCode != r_keyCode));
    w_commit  = w_frameEnd && (w_nextCnt == DB_MAX) && w_differs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowMeta <= '1;
      r_rowSync <= '1;
    end else begin
      r_rowMeta <= bus.row;
      r_rowSync <= r_rowMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick     <= '0;
      r_colIdx   <= '0;
      r_col      <= colDrive('0);
      r_accCount <= '0;
      r_accCode  <= '0;
    end else begin
      if (w_tickLast) begin
        r_tick   <= '0;
        r_colIdx <= w_nextCol;
        r_col    <= colDrive(w_nextCol);
      end else begin
        r_tick <= r_tick + TW'(1);
      end
      if (w_frameEnd) begin
        r_accCount <= '0;
        r_accCode  <= '0;
      end else if (w_sample) begin
        if (r_accCount == 2'd0) r_accCode <= w_firstCode;
        r_accCount <= w_accSum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevKind   <= CAND_NONE;
      r_prevCode   <= '0;
      r_dbCnt      <= '0;
      r_comKind    <= CAND_NONE;
      r_keyCode    <= '0;
      r_keyValid   <= 1'b0;
      r_keyPress   <= 1'b0;
      r_keyRelease <= 1'b0;
      r_multiKey   <= 1'b0;
    end else begin
      r_keyPress   <= 1'b0;
      r_keyRelease <= 1'b0;
      if (w_frameEnd) begin
        r_prevKind <= w_candKind;
        r_prevCode <= r_accCode;
        r_dbCnt    <= w_nextCnt;
      end
      if (w_commit) begin
        r_comKind    <= w_candKind;
        r_keyRelease <= (r_comKind == CAND_KEY);
        case (w_candKind)
          CAND_KEY: begin
            r_keyCode  <= r_accCode;
            r_keyValid <= 1'b1;
            r_keyPress <= 1'b1;
            r_multiKey <= 1'b0;
          end
          CAND_MULTI: begin
            r_keyValid <= 1'b0;
            r_multiKey <= 1'b1;
          end
          default: begin
            r_keyValid <= 1'b0;
            r_multiKey <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.col         = r_col;
  assign bus.key_code    = r_keyCode;
  assign bus.key_valid   = r_keyValid;
  assign bus.key_press   = r_keyPress;
  assign bus.key_release = r_keyRelease;
  assign bus.multi_key   = r_multiKey;
endmodule

// File: tb/tb_keypad_scanner_db.sv
// Directed bench for keypad_scanner_db: a 4x4 legend-mapped instance driven by a keypad model,
// plus a 3x4 raw-index instance with one key held.
module tb_keypad_scanner_db;
  localparam int SCAN   = 16;
  localparam int SETTLE = 4;
  localparam int DB     = 2;
  localparam int FRAME  = 64;

  typedef struct { int atCyc; logic [3:0] col; } colVec_t;
  typedef struct { int r; int c; logic [3:0] code; } keyVec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_db_if #(.N_ROWS(4), .N_COLS(4), .HEX_MAP(1)) hexBus ();
  keypad_scanner_db_if #(.N_ROWS(3), .N_COLS(4), .HEX_MAP(0)) rawBus ();

  keypad_scanner_db #(.N_ROWS(4), .N_COLS(4), .SCAN_TICKS(SCAN), .SETTLE_TICKS(SETTLE),
                      .DEBOUNCE_SCANS(DB), .HEX_MAP(1))
    dutHex (.clk(clk), .rst_n(rst_n), .bus(hexBus.master));

  keypad_scanner_db #(.N_ROWS(3), .N_COLS(4), .SCAN_TICKS(SCAN), .SETTLE_TICKS(SETTLE),
                      .DEBOUNCE_SCANS(DB), .HEX_MAP(0))
    dutRaw (.clk(clk), .rst_n(rst_n), .bus(rawBus.master));

  // Keypad model: keyDown[r*4+c] shorts row r to column c.
  logic [15:0] keyDown = '0;
  always_comb begin
    hexBus.row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyDown[r*4+c] && !hexBus.col[3-c]) hexBus.row[3-r] = 1'b0;
  end
  // Raw instance: row 2 / column 3 permanently held, expected code 2*4+3 = 11.
  assign rawBus.row = {2'b11, rawBus.col[0]};

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int   pressSeen = 0, releaseSeen = 0, wideStrobes = 0;
  logic prevPress = 1'b0, prevRelease = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hexBus.key_press)   pressSeen   <= pressSeen + 1;
      if (hexBus.key_release) releaseSeen <= releaseSeen + 1;
      if ((hexBus.key_press && prevPress) || (hexBus.key_release && prevRelease))
        wideStrobes <= wideStrobes + 1;
    end
    prevPress   <= hexBus.key_press;
    prevRelease <= hexBus.key_release;
  end

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down);
    keyDown[r*4+c] = down;
  endtask

  function automatic bit eventHit(input int which);
    case (which)
      0:       return hexBus.key_press;
      1:       return hexBus.key_release;
      2:       return hexBus.multi_key;
      default: return !hexBus.multi_key;
    endcase
  endfunction

  task automatic waitEvent(input int which, input int budget, output int atCyc);
    bit found;
    found = 1'b0;
    atCyc = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (eventHit(which)) begin
        found = 1'b1;
        atCyc = cyc;
      end
    end
  endtask

  task automatic waitUntil(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic alignFrame(output int startCyc);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (cyc % FRAME == 0) break;
    end
    startCyc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  colVec_t colVecs [6];
  keyVec_t keyVecs [16];

  initial begin
    int at, s, pBefore, rBefore;

    colVecs[0] = '{15, 4'b0111};
    colVecs[1] = '{16, 4'b1011};
    colVecs[2] = '{32, 4'b1101};
    colVecs[3] = '{47, 4'b1101};
    colVecs[4] = '{48, 4'b1110};
    colVecs[5] = '{64, 4'b0111};

    keyVecs[0]  = '{0, 0, 4'h1}; keyVecs[1]  = '{1, 0, 4'h4};
    keyVecs[2]  = '{2, 0, 4'h7}; keyVecs[3]  = '{3, 0, 4'h0};
    keyVecs[4]  = '{0, 1, 4'h2}; keyVecs[5]  = '{1, 1, 4'h5};
    keyVecs[6]  = '{2, 1, 4'h8}; keyVecs[7]  = '{3, 1, 4'hF};
    keyVecs[8]  = '{0, 2, 4'h3}; keyVecs[9]  = '{1, 2, 4'h6};
    keyVecs[10] = '{2, 2, 4'h9}; keyVecs[11] = '{3, 2, 4'hE};
    keyVecs[12] = '{0, 3, 4'hA}; keyVecs[13] = '{1, 3, 4'hB};
    keyVecs[14] = '{2, 3, 4'hC}; keyVecs[15] = '{3, 3, 4'hD};

    applyStimulus(1, 1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset col",         hexBus.col,         4'b0111);
    checkOutput("reset key_code",    hexBus.key_code,    0);
    checkOutput("reset key_valid",   hexBus.key_valid,   0);
    checkOutput("reset key_press",   hexBus.key_press,   0);
    checkOutput("reset key_release", hexBus.key_release, 0);
    checkOutput("reset multi_key",   hexBus.multi_key,   0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      waitUntil(colVecs[i].atCyc);
      checkOutput($sformatf("col at cycle %0d", colVecs[i].atCyc), hexBus.col, colVecs[i].col);
    end

    // "5" held since reset exit: commits at end of frame 1 plus one cycle.
    waitEvent(0, 200, at);
    checkOutput("press 5 cycle",      at, 128);
    checkOutput("press 5 key_code",   hexBus.key_code, 4'h5);
    checkOutput("press 5 key_valid",  hexBus.key_valid, 1);
    checkOutput("raw press strobe",   rawBus.key_press, 1);
    checkOutput("raw key_code",       rawBus.key_code, 11);
    @(negedge clk);
    checkOutput("press 5 one cycle",  hexBus.key_press, 0);

    alignFrame(s);
    applyStimulus(1, 1, 1'b0);
    waitEvent(1, 200, at);
    checkOutput("release 5 cycle",     at, s + 128);
    checkOutput("release 5 key_valid", hexBus.key_valid, 0);
    checkOutput("release 5 key_code",  hexBus.key_code, 4'h5);
    checkOutput("release 5 no press",  hexBus.key_press, 0);

    for (int i = 0; i < 16; i++) begin
      alignFrame(s);
      applyStimulus(keyVecs[i].r, keyVecs[i].c, 1'b1);
      waitEvent(0, 200, at);
      checkOutput($sformatf("legend r%0d c%0d press cycle", keyVecs[i].r, keyVecs[i].c), at, s + 128);
      checkOutput($sformatf("legend r%0d c%0d code", keyVecs[i].r, keyVecs[i].c), hexBus.key_code, keyVecs[i].code);
      applyStimulus(keyVecs[i].r, keyVecs[i].c, 1'b0);
      waitEvent(1, 200, at);
      checkOutput($sformatf("legend r%0d c%0d release cycle", keyVecs[i].r, keyVecs[i].c), at, s + 256);
    end

    alignFrame(s);
    pBefore = pressSeen;
    applyStimulus(0, 0, 1'b1);
    applyStimulus(3, 3, 1'b1);
    waitEvent(2, 200, at);
    checkOutput("multi set cycle",    at, s + 128);
    checkOutput("multi key_valid",    hexBus.key_valid, 0);
    checkOutput("multi no release",   hexBus.key_release, 0);
    keyDown = '0;
    waitEvent(3, 200, at);
    checkOutput("multi clear cycle",  at, s + 256);
    checkOutput("multi no key_press", pressSeen, pBefore);

    alignFrame(s);
    pBefore = pressSeen;
    rBefore = releaseSeen;
    waitUntil(s + 34);
    applyStimulus(2, 2, 1'b1);
    waitUntil(s + 44);
    applyStimulus(2, 2, 1'b0);
    waitUntil(s + 256);
    checkOutput("glitch no press",     pressSeen, pBefore);
    checkOutput("glitch no release",   releaseSeen, rBefore);
    checkOutput("glitch key_valid",    hexBus.key_valid, 0);

    alignFrame(s);
    applyStimulus(0, 3, 1'b1);
    waitEvent(0, 200, at);
    checkOutput("press A cycle",       at, s + 128);
    checkOutput("press A code",        hexBus.key_code, 4'hA);
    applyStimulus(0, 3, 1'b0);
    applyStimulus(0, 2, 1'b1);
    waitEvent(0, 200, at);
    checkOutput("switch 3 cycle",      at, s + 256);
    checkOutput("switch 3 release",    hexBus.key_release, 1);
    checkOutput("switch 3 code",       hexBus.key_code, 4'h3);
    checkOutput("switch 3 key_valid",  hexBus.key_valid, 1);

    alignFrame(s);
    applyStimulus(0, 2, 1'b0);
    applyStimulus(2, 0, 1'b1);
    waitEvent(0, 200, at);
    checkOutput("press 7 cycle",       at, s + 128);
    checkOutput("press 7 code",        hexBus.key_code, 4'h7);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset key_valid", hexBus.key_valid, 0);
    checkOutput("async reset key_code",  hexBus.key_code, 0);
    checkOutput("async reset col",       hexBus.col, 4'b0111);
    checkOutput("async reset raw valid", rawBus.key_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rBefore = releaseSeen;
    waitEvent(0, 200, at);
    checkOutput("recommit 7 cycle",      at, 128);
    checkOutput("recommit 7 code",       hexBus.key_code, 4'h7);
    checkOutput("recommit 7 no release", hexBus.key_release, 0);
    checkOutput("no release after reset", releaseSeen, rBefore);
    checkOutput("raw recommit code",     rawBus.key_code, 11);
    checkOutput("raw recommit valid",    rawBus.key_valid, 1);
    @(negedge clk);
    checkOutput("strobe width",          wideStrobes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner_db.md
Name: keypad_scanner_db

Overview:
Parameterised matrix-keypad scanner that succeeds the fixed 4x4 column-scan decoder. It drives one column low at a time and samples synchronised row inputs. It debounces the per-frame result over several full frames and reports the key as a level plus press/release strobes. It also flags multi-key presses instead of letting the last-sampled key win. It feeds the seven-segment display path and any FSM that consumes keypad input.

Parameters:
N_ROWS, 4, number of row inputs (2..8)
N_COLS, 4, number of column outputs (2..8)
SCAN_TICKS, 100000, clk cycles each column is driven (>= SETTLE_TICKS+2)
SETTLE_TICKS, 8, cycles after column change before the rows are sampled (>= 3)
DEBOUNCE_SCANS, 3, consecutive identical frames required to commit (>= 1)
HEX_MAP, 1, 1 = legend map (only if 4x4), 0 = raw index
CW, $clog2(N_ROWS*N_COLS) (min 4 when HEX_MAP=1), key code width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row  in  N_ROWS  raw keypad rows, active-low, asynchronous
col  out  N_COLS  column drive, one-cold active-low
key_code  out  CW  last committed key
key_valid  out  1  high while a single debounced key is held
key_press  out  1  1-cycle strobe, new key committed
key_release  out  1  1-cycle strobe, key released or replaced
multi_key  out  1  high while debounced state is ">1 key pressed"

Behaviour:
- Reset: all outputs reset asynchronously.
  - col = 0 at MSB, 1 elsewhere (column 0 driven).
  - key_code=0, key_valid=0, key_press=0, key_release=0, multi_key=0.
  - Tick counter, column index, frame accumulator and debounce counter cleared; synchronisers reset to all-1s.
- Bit mapping:
  - Column c drives bit N_COLS-1-c low.
  - Row r is pressed when bit N_ROWS-1-r reads 0.
- Synchroniser: row passes through a 2-FF synchroniser before any use.
- Tick counter: 0..SCAN_TICKS-1 per column.
  - At the wrap, the column index advances (mod N_COLS) and col updates in that same cycle.
- Sampling: at tick == SETTLE_TICKS the synchronised rows for the current column are sampled once into the frame accumulator. The accumulator holds:
  - count of pressed keys, saturating at 2;
  - index of the first pressed key found.
- Raw index = row*N_COLS + col.
- HEX_MAP=1 legend:
  - col0 rows 0..3 = 1,4,7,0
  - col1 = 2,5,8,F
  - col2 = 3,6,9,E
  - col3 = A,B,C,D
- Frame end: the last tick of column N_COLS-1. The candidate is:
  - NONE if count 0;
  - KEY(code) if count 1;
  - MULTI if count 2.
  - The accumulator is cleared for the next frame in the same cycle.
- Debounce:
  - If the candidate equals the previous frame's candidate (including the same code), the counter increments, saturating.
  - Otherwise the counter is set to 1.
  - When the counter reaches DEBOUNCE_SCANS and the candidate differs from the committed state, the candidate is committed on the cycle after frame end.
- On commit:
  - KEY(k) from NONE: key_code=k, key_valid=1, key_press pulses.
  - KEY(k) from KEY(j), k!=j: key_release and key_press pulse in the same cycle; key_code=k.
  - NONE from KEY: key_release pulses, key_valid=0, key_code holds.
  - MULTI: multi_key=1, key_valid=0, key_release pulses if previously KEY, key_code holds.
  - Leaving MULTI: multi_key=0.
- Strobes are never asserted for more than one cycle.
- Latency: a press stable before frame F's sampling commits at (frame F+DEBOUNCE_SCANS-1 end)+1 cycle.
- Bounce: any frame differing from its predecessor restarts the count. A bounce shorter than one frame causes at most one candidate deviation and no spurious strobes.
- Reset mid-scan: all state is lost and scanning restarts at column 0, tick 0; no strobe is issued on reset exit.

Test Plan:
- Params N_ROWS=N_COLS=4, SCAN_TICKS=16, SETTLE_TICKS=4, DEBOUNCE_SCANS=2, HEX_MAP=1; frame = 64 cycles.
  - Reset -> col=4'b0111, all outputs 0; col steps 0111→1011→1101→1110 every 16 cycles, wraps to 0111.
  - Hold key "5" (col1,row1) -> key_press one cycle, key_code=4'h5, key_valid=1, at end of 2nd full frame +1.
  - Release "5" -> key_release one cycle after 2 stable empty frames; key_valid=0; key_code stays 5.
  - Press "1" and "D" together -> multi_key=1, key_valid=0, no key_press.
  - Glitch "9" for 10 cycles inside a single frame -> no strobe, key_valid stays 0.
- Switch from "A" to "3" held -> key_release and key_press in the same cycle, key_code=4'h3.
- Assert rst_n=0 mid-frame while "7" is committed -> outputs 0 asynchronously; after release, "7" recommits with key_press after 2 frames.
- HEX_MAP=0, N_ROWS=3, N_COLS=4: press row2,col3 -> key_code=11.
